pwm_multi_channel: RTL

Multi-channel successor to the single-channel PWM generator. It provides CHANNELS independent duty-cycle outputs driven from one shared period counter. The period is programmable, and compare and period writes go through shadow registers that take effect only at a period boundary, so outputs never glitch. The counter advances either on every sys_clk cycle or on synchronised rising edges of the slow external clk_in. The block sits between the register-write front end (wr strobe plus data) and the output pads.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_multi_channel_tick_gen.sv | 35 +++
 rtl/pwm_multi_channel.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: count direction
// encoding and the all-ones compare constant helper.
package pwm_pkg;

   // Direction of the shared period counter; only center-aligned builds
   // ever leave DIR_UP.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_e;

   // All-ones value of a given bit width. A compare register holding this
   // value forces its output permanently high.
   function automatic logic [31:0] pwm_all_ones(input int unsigned width);
      if (width >= 32) begin
         return '1;
      end
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_multi_channel_tick_gen.sv
// Count-enable generator for the shared PWM counter. clk_in is
// asynchronous to sys_clk, so it is brought in through a two-flop
// synchroniser and a single-flop rising-edge detector. use_sys bypasses
// the external strobe and counts every sys_clk cycle.
module pwm_tick_gen
   import pwm_pkg::*;
(
   input  logic sys_clk,
   input  logic rst_n,
   input  logic clk_in,
   input  logic use_sys,
   output logic tick
);

   logic sync1_q;
   logic sync2_q;
   logic edge_q;

   // Synchroniser chain plus delayed copy used for edge detection.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         sync1_q <= clk_in;
         sync2_q <= sync1_q;
         edge_q  <= sync2_q;
      end
   end

   // One-cycle pulse per synchronised clk_in rise, or constant count.
   assign tick = use_sys | (sync2_q & ~edge_q);

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: CHANNELS compare outputs share one
// programmable period counter. Period and compare writes land in shadow
// registers and are copied to the active set only at a period boundary,
// so outputs never glitch mid-period.
// Optional feature: define PWM_CENTER_ALIGN_EN to add the center input,
// which selects up/down (center-aligned) counting at each load point.
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int COMPARE_SIZE = 8,
   parameter int CHANNELS     = 4,
   parameter int CH_SEL_SIZE  = 2
) (
   input  logic                    sys_clk,
   input  logic                    rst_n,
   input  logic                    clk_in,
   input  logic                    use_sys,
   input  logic                    wr,
   input  logic                    wr_period,
   input  logic [CH_SEL_SIZE-1:0]  wr_sel,
   input  logic [COMPARE_SIZE-1:0] data_in,
   input  logic [CHANNELS-1:0]     ena,
`ifdef PWM_CENTER_ALIGN_EN
   input  logic                    center,
`endif
   output logic [CHANNELS-1:0]     pwm_out
);

   localparam logic [COMPARE_SIZE-1:0] CMP_MAX =
      COMPARE_SIZE'(pwm_all_ones(COMPARE_SIZE));
   localparam logic [COMPARE_SIZE-1:0] CNT_ONE = COMPARE_SIZE'(1);

   logic                    tick;
   logic                    wr_q;
   logic                    wr_fire;
   logic [COMPARE_SIZE-1:0] period_sh_q;
   logic [COMPARE_SIZE-1:0] period_act_q;
   logic [COMPARE_SIZE-1:0] cnt_q;
   logic [COMPARE_SIZE-1:0] cnt_d;
   logic                    load;
   logic                    wrap;

`ifdef PWM_CENTER_ALIGN_EN
   pwm_dir_e dir_q;
   pwm_dir_e dir_d;
   logic     center_q;
`endif

   pwm_tick_gen u_tick_gen (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .clk_in  (clk_in),
      .use_sys (use_sys),
      .tick    (tick)
   );

   // A held wr strobe performs exactly one write, on its rising edge.
   assign wr_fire = wr & ~wr_q;

   // Edge-aligned terminal count: wrap to zero and reload the active set.
   assign wrap = (cnt_q == period_act_q);

   // Next counter value and load strobe for the shared period counter.
   always_comb begin
      cnt_d = cnt_q;
      load  = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d = dir_q;
      if (tick && center_q && (period_act_q != '0)) begin
         if (dir_q == DIR_UP) begin
            if (cnt_q >= period_act_q) begin
               cnt_d = cnt_q - CNT_ONE;
               dir_d = DIR_DOWN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else begin
            // Reaching zero on the way down closes the symmetric period.
            if (cnt_q <= CNT_ONE) begin
               cnt_d = '0;
               dir_d = DIR_UP;
               load  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
      end else if (tick) begin
         dir_d = DIR_UP;
         if (wrap) begin
            cnt_d = '0;
            load  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
`else
      if (tick) begin
         if (wrap) begin
            cnt_d = '0;
            load  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
`endif
   end

   // Counter, write edge detector and period shadow/active pair. On a
   // boundary the active register takes the pre-edge shadow, so a write
   // on the same edge only applies from the following boundary.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q         <= 1'b0;
         cnt_q        <= '0;
         period_sh_q  <= CMP_MAX;
         period_act_q <= CMP_MAX;
      end else begin
         wr_q  <= wr;
         cnt_q <= cnt_d;
         if (wr_fire && wr_period) begin
            period_sh_q <= data_in;
         end
         if (load) begin
            period_act_q <= period_sh_q;
         end
      end
   end

`ifdef PWM_CENTER_ALIGN_EN
   // Count direction and center-mode selection, latched at load points.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q    <= DIR_UP;
         center_q <= 1'b0;
      end else begin
         dir_q <= dir_d;
         if (load) begin
            center_q <= center;
         end
      end
   end
`endif

   // Per-channel compare shadow/active registers and output comparator.
   // Channel indices not present never match wr_sel, so out-of-range
   // compare writes are dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [COMPARE_SIZE-1:0] cmp_sh_q;
      logic [COMPARE_SIZE-1:0] cmp_act_q;
      logic                    pwm_q;

      // Compare registers and the registered output of channel i.
      always_ff @(posedge sys_clk or negedge rst_n) begin
         if (!rst_n) begin
            cmp_sh_q  <= '0;
            cmp_act_q <= '0;
            pwm_q     <= 1'b0;
         end else begin
            if (wr_fire && !wr_period && (wr_sel == CH_SEL_SIZE'(i))) begin
               cmp_sh_q <= data_in;
            end
            if (load) begin
               cmp_act_q <= cmp_sh_q;
            end
            pwm_q <= ena[i] & ((cmp_act_q == CMP_MAX) | (cnt_q < cmp_act_q));
         end
      end

      assign pwm_out[i] = pwm_q;
   end

endmodule
